// File: rtl/puf_pkg.sv
// Purpose: shared types, default parameters and counter-width helper for the PUF response reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RELEASE,
        ST_FIRE,
        ST_SAMPLE,
        ST_DONE
    } puf_rd_state_t;

    localparam int DEF_RESP_BITS  = 8;
    localparam int DEF_N_EVAL     = 15;
    localparam int DEF_SETTLE_CYC = 4;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/puf_response_reader_sync2.sv
// Purpose: two-flop synchronizer bringing the asynchronous PUF cell output into the clk domain.
// Latency: 2 clk cycles from input to output.
// Backpressure: none; free-running.
// Ports: clk (clock), clear (sync active-high reset, flops to 0), i_d (async in), o_q (synchronized out).
module sync2 (
    input  logic clk,
    input  logic clear,
    input  logic i_d,
    output logic o_q
);

    // Kept as two distinct flops so synthesis cannot merge or retime the pair.
    (* dont_touch = "true" *) logic r_meta;
    (* dont_touch = "true" *) logic r_sync;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/puf_response_reader.sv
// Purpose: sequences arm/release/fire/sample over each PUF cell, majority-votes N_EVAL samples per bit.
// Latency: resp_valid in cycle RESP_BITS*N_EVAL*(2*SETTLE_CYC+4)+1 after start is sampled.
// Backpressure: none; start is ignored while busy, no queueing.
// Ports: clk/clear (sync active-high reset); start -> busy; puf_sel/puf_clear/puf_fire drive the cell
//        array, puf_o is the selected cell output; resp/resp_unstable qualified by one-cycle resp_valid.
module puf_response_reader
    import puf_pkg::*;
#(
    parameter int RESP_BITS  = DEF_RESP_BITS,
    parameter int N_EVAL     = DEF_N_EVAL,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         start,
    output logic                         busy,
    output logic [$clog2(RESP_BITS)-1:0] puf_sel,
    output logic                         puf_clear,
    output logic                         puf_fire,
    input  logic                         puf_o,
    output logic [RESP_BITS-1:0]         resp,
    output logic [RESP_BITS-1:0]         resp_unstable,
    output logic                         resp_valid
);

    localparam int SEL_W  = $clog2(RESP_BITS);
    localparam int ONES_W = cnt_w(N_EVAL + 1);
    localparam int EVAL_W = cnt_w(N_EVAL);
    localparam int PH_W   = cnt_w(SETTLE_CYC + 2);

    puf_rd_state_t          r_state;
    logic [PH_W-1:0]        r_phase;
    logic [EVAL_W-1:0]      r_eval;
    logic [ONES_W-1:0]      r_ones;
    logic [SEL_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_clr;
    logic                   r_fire;
    logic                   r_valid;
    logic [RESP_BITS-1:0]   r_resp_sh;
    logic [RESP_BITS-1:0]   r_unst_sh;
    logic [RESP_BITS-1:0]   r_resp;
    logic [RESP_BITS-1:0]   r_unst;

    logic                   w_puf_sync;
    logic [ONES_W-1:0]      w_ones_nxt;
    logic                   w_bit;
    logic                   w_unst;
    logic                   w_last_eval;
    logic                   w_last_bit;
    logic [RESP_BITS-1:0]   w_resp_nxt;
    logic [RESP_BITS-1:0]   w_unst_nxt;

    sync2 u_sync2 (
        .clk   (clk),
        .clear (clear),
        .i_d   (puf_o),
        .o_q   (w_puf_sync)
    );

    // Vote including the sample taken in the current SAMPLE cycle.
    assign w_ones_nxt  = r_ones + ONES_W'(w_puf_sync);
    assign w_bit       = (w_ones_nxt > ONES_W'(N_EVAL / 2));
    assign w_unst      = (w_ones_nxt != '0) && (w_ones_nxt != ONES_W'(N_EVAL));
    assign w_last_eval = (r_eval == EVAL_W'(N_EVAL - 1));
    assign w_last_bit  = (r_idx == SEL_W'(RESP_BITS - 1));

    always_comb begin
        w_resp_nxt        = r_resp_sh;
        w_unst_nxt        = r_unst_sh;
        w_resp_nxt[r_idx] = w_bit;
        w_unst_nxt[r_idx] = w_unst;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_eval    <= '0;
            r_ones    <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_clr     <= 1'b1;
            r_fire    <= 1'b0;
            r_valid   <= 1'b0;
            r_resp_sh <= '0;
            r_unst_sh <= '0;
            r_resp    <= '0;
            r_unst    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clr   <= 1'b1;
                    r_fire  <= 1'b0;
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= ST_ARM;
                        r_busy  <= 1'b1;
                        r_phase <= '0;
                        r_eval  <= '0;
                        r_ones  <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_ARM: begin
                    if (r_phase == PH_W'(SETTLE_CYC - 1)) begin
                        r_phase <= '0;
                        r_clr   <= 1'b0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // One cycle with both cell inputs low before the launch edge.
                    r_fire  <= 1'b1;
                    r_phase <= '0;
                    r_state <= ST_FIRE;
                end
                ST_FIRE: begin
                    // Two extra cycles let the race result cross the synchronizer.
                    if (r_phase == PH_W'(SETTLE_CYC + 1)) begin
                        r_phase <= '0;
                        r_fire  <= 1'b0;
                        r_clr   <= 1'b1;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (!w_last_eval) begin
                        r_eval  <= r_eval + EVAL_W'(1);
                        r_ones  <= w_ones_nxt;
                        r_state <= ST_ARM;
                    end else begin
                        r_resp_sh <= w_resp_nxt;
                        r_unst_sh <= w_unst_nxt;
                        r_eval    <= '0;
                        r_ones    <= '0;
                        if (w_last_bit) begin
                            // Publish the completed shadow so resp is valid with the pulse.
                            r_idx   <= '0;
                            r_resp  <= w_resp_nxt;
                            r_unst  <= w_unst_nxt;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + SEL_W'(1);
                            r_state <= ST_ARM;
                        end
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign puf_sel       = r_idx;
    assign puf_clear     = r_clr;
    assign puf_fire      = r_fire;
    assign resp          = r_resp;
    assign resp_unstable = r_unst;
    assign resp_valid    = r_valid;

endmodule

// File: tb/tb_puf_response_reader.sv
// Purpose: scoreboard bench for puf_response_reader (default and minimal parameter sets).
// Latency: checks resp_valid arrival cycle against the hand-computed figure.
// Backpressure: n/a.
module tb_puf_response_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear, start, start2;
    logic       busy, puf_clear, puf_fire, puf_o, resp_valid;
    logic [2:0] puf_sel;
    logic [7:0] resp, resp_unstable;

    logic       busy2, clr2, fire2, puf_o2, valid2;
    logic [0:0] sel2;
    logic [1:0] resp2, unst2;

    int mode    = 0;
    int tog_cnt = 0;
    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int viol    = 0;
    int fire_rises = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] u;
        int         c0;
        int         lat;
    } exp_t;
    exp_t q[$];
    exp_t q2[$];

    puf_response_reader dut (
        .clk           (clk),
        .clear         (clear),
        .start         (start),
        .busy          (busy),
        .puf_sel       (puf_sel),
        .puf_clear     (puf_clear),
        .puf_fire      (puf_fire),
        .puf_o         (puf_o),
        .resp          (resp),
        .resp_unstable (resp_unstable),
        .resp_valid    (resp_valid)
    );

    puf_response_reader #(.RESP_BITS(2), .N_EVAL(1), .SETTLE_CYC(1)) dut_small (
        .clk           (clk),
        .clear         (clear),
        .start         (start2),
        .busy          (busy2),
        .puf_sel       (sel2),
        .puf_clear     (clr2),
        .puf_fire      (fire2),
        .puf_o         (puf_o2),
        .resp          (resp2),
        .resp_unstable (unst2),
        .resp_valid    (valid2)
    );

    // Cell models: mode 0 all ones, mode 1 cell output = index LSB, mode 2 cell 3 toggles per evaluation.
    assign puf_o  = (mode == 0) ? 1'b1 :
                    (mode == 1) ? puf_sel[0] :
                    (puf_sel == 3'd3) ? tog_cnt[0] : 1'b0;
    assign puf_o2 = sel2[0];

    always @(posedge clk) cyc <= cyc + 1;

    logic tg_prev = 1'b0;
    always @(negedge clk) begin
        if (puf_fire && !tg_prev && puf_sel == 3'd3) tog_cnt = tog_cnt + 1;
        tg_prev = puf_fire;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Protocol: clear/fire never both high; every fire rise follows exactly one all-low cycle.
    logic pc_clr1 = 1'b1, pc_fire1 = 1'b0, pc_clr2 = 1'b1;
    always @(negedge clk) begin
        if (puf_clear && puf_fire) viol++;
        if (puf_fire && !pc_fire1) begin
            fire_rises++;
            if (!(!pc_clr1 && pc_clr2)) viol++;
        end
        pc_clr2  = pc_clr1;
        pc_clr1  = puf_clear;
        pc_fire1 = puf_fire;
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("resp", int'(resp), int'(e.r));
                chk("resp_unstable", int'(resp_unstable), int'(e.u));
                chk("latency", cyc - e.c0 + 1, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid2) begin
            if (q2.size() == 0) begin
                chk("small_unexpected_valid", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("small_resp", int'(resp2), int'(e.r));
                chk("small_unstable", int'(unst2), int'(e.u));
                chk("small_latency", cyc - e.c0 + 1, e.lat);
            end
        end
    end

    task automatic check_reset(input string name);
        chk(name, int'({busy, puf_sel, puf_clear, puf_fire, resp, resp_unstable, resp_valid}),
            int'({1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
        chk({name, "_small"}, int'({busy2, sel2, clr2, fire2, resp2, unst2, valid2}),
            int'({1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0}));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("timeout_idle", 1, 0);
    endtask

    task automatic do_start(input logic [7:0] r, input logic [7:0] u);
        exp_t e;
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        e.r = r; e.u = u; e.c0 = cyc + 1; e.lat = 1441;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    initial begin
        exp_t e;
        int n;
        clear  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_values");
        clear = 1'b0;

        // Minimal parameters, start held high: two back-to-back runs, 14 cycles apart.
        @(negedge clk);
        start2 = 1'b1;
        e.r = 8'h02; e.u = 8'h00; e.lat = 13;
        e.c0 = cyc + 1;  q2.push_back(e);
        e.c0 = cyc + 15; q2.push_back(e);
        n = 0;
        while (q2.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start2 = 1'b0;
        if (q2.size() != 0) chk("small_timeout", 1, 0);
        repeat (40) @(negedge clk);

        mode = 0; do_start(8'hFF, 8'h00); wait_idle();
        mode = 1; do_start(8'hAA, 8'h00); wait_idle();
        mode = 2; tog_cnt = 0; do_start(8'h08, 8'h08); wait_idle();

        // Abort mid-run with clear; no pulse may come from the aborted run.
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (498) @(negedge clk);
        clear = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("clear_mid_run");
        clear = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_clear", int'(busy), 0);
        mode = 1; do_start(8'hAA, 8'h00); wait_idle();

        // Extra start pulses while busy are ignored.
        mode = 0; do_start(8'hFF, 8'h00);
        repeat (10) begin
            repeat (97) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        repeat (30) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        chk("small_queue_drained", q2.size(), 0);
        chk("protocol_violations", viol, 0);
        chk("fire_rises_seen", int'(fire_rises > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_response_reader.md
# puf_response_reader

- Controller and reader for an array of arbiter-style PUF cells, each with `clk`/`clear` inputs and a single output.
- Selects each cell in turn, arms it by holding `clear`, launches the flip-flop race with a rising edge on the cell's clock input, then samples the result through a synchronizer.
- Repeats each evaluation `N_EVAL` times and majority-votes the samples into one response bit.
- Sits between the top-level command logic and the PUF array; delivers a `RESP_BITS`-wide response plus a per-bit instability mask.

## Interface
Parameters:
- `RESP_BITS`, 8: number of PUF cells evaluated and response width; ≥2.
- `N_EVAL`, 15: evaluations per bit; must be odd, 1..255.
- `SETTLE_CYC`, 4: cycles for arm and race settling; ≥1.

Ports (one clock `clk`; reset `clear` is synchronous and active-high):
- `clk`, in, 1: system clock.
- `clear`, in, 1: synchronous active-high reset.
- `start`, in, 1: request one full response; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` is accepted until DONE.
- `puf_sel`, out, $clog2(RESP_BITS): index of the cell under evaluation; drives the external cell mux.
- `puf_clear`, out, 1: drives the `clear` input of the selected cell.
- `puf_fire`, out, 1: drives the `clk` input of the selected cell; its rising edge launches the race.
- `puf_o`, in, 1: selected cell output; asynchronous to `clk`.
- `resp`, out, RESP_BITS: majority-voted response; bit i comes from cell i.
- `resp_unstable`, out, RESP_BITS: bit i high if the samples for cell i were not unanimous.
- `resp_valid`, out, 1: one-cycle pulse when `resp` and `resp_unstable` are updated.

## Operation
- FSM states: IDLE, ARM, RELEASE, FIRE, SAMPLE, DONE.
- IDLE:
  - `puf_clear`=1, `puf_fire`=0.
  - `start`=1 → ARM; evaluation counter, one-counter and bit index all set to 0.
- ARM: `puf_clear`=1, `puf_fire`=0 for `SETTLE_CYC` cycles → RELEASE.
- RELEASE: `puf_clear`=0, `puf_fire`=0 for 1 cycle → FIRE.
- FIRE:
  - `puf_fire`=1 for `SETTLE_CYC`+2 cycles; the extra 2 cover the 2-flop synchronizer on `puf_o`.
  - Then → SAMPLE.
- SAMPLE (1 cycle):
  - `puf_fire`=0, `puf_clear`=1.
  - Add the synchronized `puf_o` to the one-counter (width $clog2(N_EVAL+1)).
  - If more evaluations remain for this bit → ARM.
  - Otherwise:
    - Write `resp[idx]` = (ones > N_EVAL/2).
    - Write `resp_unstable[idx]` = (ones ≠ 0 && ones ≠ N_EVAL).
    - Clear the counters, then advance `idx`.
    - If `idx` was RESP_BITS-1 → DONE, else → ARM.
- DONE (1 cycle): `resp_valid`=1 → IDLE.
- `resp` and `resp_unstable` are built in shadow registers and copied to the outputs on DONE. Outputs hold their value until the next DONE.
- `start` outside IDLE is ignored; there is no queueing.
- `puf_sel` = `idx`. It changes only on the SAMPLE→ARM transition, while `puf_clear`=1.

## Timing
- Values after `clear`:
  - State IDLE.
  - `busy`=0, `puf_sel`=0, `puf_clear`=1, `puf_fire`=0.
  - `resp`=0, `resp_unstable`=0, `resp_valid`=0.
  - Synchronizer flops = 0.
- Per evaluation: 2·SETTLE_CYC+4 cycles (12 with default parameters).
- Latency: `resp_valid` is high in cycle RESP_BITS·N_EVAL·(2·SETTLE_CYC+4)+1 after the edge that samples `start`. With default parameters that is cycle 1441.
- `clear` asserted mid-operation:
  - Next edge returns all values to the reset values above.
  - Partial results are discarded and no `resp_valid` pulse is produced.
  - The cell is immediately re-armed (`puf_clear`=1).
- `puf_clear` and `puf_fire` are never both 1. Every `puf_fire` rise is preceded by exactly 1 cycle with both low.
- `start` held high through DONE: a new run begins in the cycle after DONE returns to IDLE.

## Structure
- Shared package `puf_pkg`:
  - State enum `puf_rd_state_t`.
  - Width helper for the counters.
  - Default-parameter constants.
- Sub-module `sync2`: 2-flop synchronizer for `puf_o`, reset by `clear` to 0. Keep it `dont_touch` so the flops are not merged.
- Everything else (FSM, counters, shadow registers) lives in one file.

## Test plan
- Cell model drives constant 1 for every `puf_sel`, default parameters, `start` pulse → `resp_valid` at cycle 1441; `resp`=8'hFF; `resp_unstable`=0.
- Cell model output = `puf_sel`[0] → `resp`=8'hAA; `resp_unstable`=0.
- Cell 3 toggles on each evaluation (8 ones, 7 zeros), all other cells output 0 → `resp`=8'h08; `resp_unstable`=8'h08.
- `clear` asserted at cycle 500, then `start` → no pulse from the first run; the second run completes 1441 cycles after its `start`. Reset values hold during `clear`.
- `start` pulsed repeatedly while `busy` → exactly one `resp_valid`. Protocol checker confirms `puf_clear`&&`puf_fire` is never true and RELEASE precedes every `puf_fire` rise.
- RESP_BITS=2, N_EVAL=1, SETTLE_CYC=1 → `resp_valid` at cycle 13; `resp_unstable` is always 0.
